// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the ID-stage branch predictor: counter encodings,
// default table geometry and small helpers on the 2-bit counter state.
package branch_predictor_pkg;

  localparam int PC_W = 32;
  localparam int BP_IDX_BITS = 4;
  localparam logic [1:0] BP_CNT_INIT = 2'b01;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_t;

  // The counter MSB is the taken/not-taken vote.
  function automatic logic cnt_taken(input cnt_t c);
    logic [1:0] raw;
    raw = c;
    return raw[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-facing bundle of the branch predictor: ID lookup, EX training and statistics.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic            i_id_pc_valid_unused_guard;
  logic [PC_W-1:0] i_id_pc;
  logic            i_id_is_branch;
  logic [PC_W-1:0] i_id_target;
  logic            i_stall;
  logic            i_halt;
  logic            i_upd_valid;
  logic [PC_W-1:0] i_upd_pc;
  logic            i_upd_taken;
  logic            i_mispredicted;
  logic            o_branch_prediction;
  logic [PC_W-1:0] o_branch_target;
  logic [31:0]     o_predict_count;
  logic [31:0]     o_mispredict_count;

  modport master (
    output i_id_pc, i_id_is_branch, i_id_target, i_stall, i_halt,
           i_upd_valid, i_upd_pc, i_upd_taken, i_mispredicted,
    input  o_branch_prediction, o_branch_target, o_predict_count, o_mispredict_count
  );

  modport slave (
    input  i_id_pc, i_id_is_branch, i_id_target, i_stall, i_halt,
           i_upd_valid, i_upd_pc, i_upd_taken, i_mispredicted,
    output o_branch_prediction, o_branch_target, o_predict_count, o_mispredict_count
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Pure 2-bit saturating counter next-state: moves toward strongly-taken or
// strongly-not-taken and holds at either end instead of wrapping.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  cnt_t cnt,
  input  logic taken,
  output cnt_t cnt_next
);

  // Next counter state for the resolved outcome
  always_comb begin
    cnt_next = cnt;
    case (cnt)
      CNT_SNT: cnt_next = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: cnt_next = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  cnt_next = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  cnt_next = taken ? CNT_ST  : CNT_WT;
      default: cnt_next = cnt_t'(BP_CNT_INIT);
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged table of 2-bit counters predicting ID-stage conditional branches,
// trained by EX resolutions, with lookup/misprediction statistics for debug.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         IDX_BITS = BP_IDX_BITS,
  parameter logic [1:0] CNT_INIT = BP_CNT_INIT
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES  = int'(32'd1) << IDX_BITS;
  localparam int TAG_BITS = PC_W - IDX_BITS - 2;

  logic [ENTRIES-1:0]  valid_r;
  logic [TAG_BITS-1:0] tag_r [ENTRIES];
  cnt_t                cnt_r [ENTRIES];
  logic [31:0]         predict_count_r;
  logic [31:0]         mispredict_count_r;

  logic [IDX_BITS-1:0] id_idx_s;
  logic [TAG_BITS-1:0] id_tag_s;
  logic                id_hit_s;
  logic                lookup_ok_s;
  logic [IDX_BITS-1:0] upd_idx_s;
  logic [TAG_BITS-1:0] upd_tag_s;
  logic                upd_hit_s;
  cnt_t                upd_cnt_s;
  cnt_t                upd_cnt_next_s;
  logic                unused_pc_bits_s;

  assign id_idx_s  = bp.i_id_pc[IDX_BITS+1:2];
  assign id_tag_s  = bp.i_id_pc[PC_W-1:IDX_BITS+2];
  assign upd_idx_s = bp.i_upd_pc[IDX_BITS+1:2];
  assign upd_tag_s = bp.i_upd_pc[PC_W-1:IDX_BITS+2];
  assign unused_pc_bits_s = ^{bp.i_id_pc[1:0], bp.i_upd_pc[1:0]};

  // A branch only "counts" when it actually leaves ID this cycle
  always_comb begin
    lookup_ok_s = bp.i_id_is_branch && !bp.i_stall && !bp.i_halt && !bp.i_mispredicted;
    id_hit_s    = valid_r[id_idx_s] && (tag_r[id_idx_s] == id_tag_s);
  end

  // Same-cycle lookup against the table contents from before this edge
  always_comb begin
    bp.o_branch_prediction = lookup_ok_s && id_hit_s && cnt_taken(cnt_r[id_idx_s]) && !reset;
    bp.o_branch_target     = bp.i_id_target;
  end

  // Training side: hit check and counter read for the resolved branch
  always_comb begin
    upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    upd_cnt_s = cnt_r[upd_idx_s];
  end

  sat_counter2 u_sat_counter2 (
    .cnt      (upd_cnt_s),
    .taken    (bp.i_upd_taken),
    .cnt_next (upd_cnt_next_s)
  );

  // Table state; a taken miss evicts whatever occupies the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i] <= {TAG_BITS{1'b0}};
        cnt_r[i] <= cnt_t'(CNT_INIT);
      end
    end else if (bp.i_upd_valid) begin
      if (upd_hit_s) begin
        cnt_r[upd_idx_s] <= upd_cnt_next_s;
      end else if (bp.i_upd_taken) begin
        valid_r[upd_idx_s] <= 1'b1;
        tag_r[upd_idx_s]   <= upd_tag_s;
        cnt_r[upd_idx_s]   <= CNT_WT;
      end else begin
        valid_r[upd_idx_s] <= valid_r[upd_idx_s];
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  // Debug statistics, free-running modulo 2**32
  always_ff @(posedge clk) begin
    if (reset) begin
      predict_count_r    <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else begin
      if (lookup_ok_s) begin
        predict_count_r <= predict_count_r + 32'd1;
      end else begin
        predict_count_r <= predict_count_r;
      end
      if (bp.i_mispredicted && bp.i_upd_valid) begin
        mispredict_count_r <= mispredict_count_r + 32'd1;
      end else begin
        mispredict_count_r <= mispredict_count_r;
      end
    end
  end

  assign bp.o_predict_count    = predict_count_r;
  assign bp.o_mispredict_count = mispredict_count_r;

endmodule
